id_ex_stage: RTL and testbench

ID/EX pipeline register with integrated load-use hazard detection for the 16-register pipelined CPU. The block captures decoded operands and control from the decode stage and presents them to the execute stage. Its `r1IDEX`/`r2IDEX` outputs drive the forwarding unit directly. It generates the decode/fetch stall, inserts bubbles on load-use hazards, and clears its contents on branch flush.

---
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and branch flush.
// Optional load-use stall counter is built when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [3:0]    id_r1,
  input  logic [3:0]    id_r2,
  input  logic [3:0]    id_rd,
  input  logic          id_use_r1,
  input  logic          id_use_r2,
  input  logic [DW-1:0] id_rdata1,
  input  logic [DW-1:0] id_rdata2,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          stall_id,
  output logic          ex_valid,
  output logic [3:0]    r1IDEX,
  output logic [3:0]    r2IDEX,
  output logic [3:0]    rdIDEX,
  output logic [DW-1:0] ex_rdata1,
  output logic [DW-1:0] ex_rdata2,
  output logic [DW-1:0] ex_imm,
  output logic [3:0]    ex_alu_op,
  output logic          ex_alu_src,
  output logic          regWriteIDEX,
  output logic          memReadIDEX,
  output logic          memWriteIDEX,
  output logic          memToRegIDEX,
  output logic [15:0]   stall_count
);

  logic lu;
  logic load_bubble;
  logic capture;

  // A load writing r0 never creates a dependency, so rd==0 suppresses the hazard.
  assign lu = ex_valid & memReadIDEX & (rdIDEX != 4'd0) & id_valid &
              ((id_use_r1 & (id_r1 == rdIDEX)) | (id_use_r2 & (id_r2 == rdIDEX)));

  assign stall_id    = !flush & (lu | ex_hold);
  assign load_bubble = flush | (!ex_hold & lu);
  assign capture     = !flush & !ex_hold & !lu;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      r1IDEX       <= '0;
      r2IDEX       <= '0;
      rdIDEX       <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      regWriteIDEX <= 1'b0;
      memReadIDEX  <= 1'b0;
      memWriteIDEX <= 1'b0;
      memToRegIDEX <= 1'b0;
    end else if (load_bubble) begin
      // Zeroed register numbers keep the forwarding unit from matching a bubble.
      ex_valid     <= 1'b0;
      r1IDEX       <= '0;
      r2IDEX       <= '0;
      rdIDEX       <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_alu_op    <= '0;
      ex_alu_src   <= 1'b0;
      regWriteIDEX <= 1'b0;
      memReadIDEX  <= 1'b0;
      memWriteIDEX <= 1'b0;
      memToRegIDEX <= 1'b0;
    end else if (capture) begin
      ex_valid     <= id_valid;
      r1IDEX       <= id_r1;
      r2IDEX       <= id_r2;
      rdIDEX       <= id_rd;
      ex_rdata1    <= id_rdata1;
      ex_rdata2    <= id_rdata2;
      ex_imm       <= id_imm;
      ex_alu_op    <= id_alu_op;
      ex_alu_src   <= id_alu_src;
      regWriteIDEX <= id_reg_write;
      memReadIDEX  <= id_mem_read;
      memWriteIDEX <= id_mem_write;
      memToRegIDEX <= id_mem_to_reg;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (lu && !flush && !ex_hold && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign stall_count = cnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes hand-computed expectations, monitor pops and compares.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  rd;
    logic        use1;
    logic        use2;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic [15:0] imm;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
  } id_t;

  typedef struct {
    string       name;
    logic        stall;
    id_t         ex;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  id_t         id;
  logic        flush;
  logic        ex_hold;
  logic        stall_id;
  logic        ex_valid;
  logic [3:0]  r1IDEX, r2IDEX, rdIDEX;
  logic [15:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src, regWriteIDEX, memReadIDEX, memWriteIDEX, memToRegIDEX;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id.valid), .id_r1(id.r1), .id_r2(id.r2), .id_rd(id.rd),
    .id_use_r1(id.use1), .id_use_r2(id.use2),
    .id_rdata1(id.rdata1), .id_rdata2(id.rdata2), .id_imm(id.imm),
    .id_alu_op(id.alu_op), .id_alu_src(id.alu_src), .id_reg_write(id.rw),
    .id_mem_read(id.mr), .id_mem_write(id.mw), .id_mem_to_reg(id.m2r),
    .flush(flush), .ex_hold(ex_hold), .stall_id(stall_id),
    .ex_valid(ex_valid), .r1IDEX(r1IDEX), .r2IDEX(r2IDEX), .rdIDEX(rdIDEX),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .regWriteIDEX(regWriteIDEX), .memReadIDEX(memReadIDEX),
    .memWriteIDEX(memWriteIDEX), .memToRegIDEX(memToRegIDEX),
    .stall_count(stall_count)
  );

  // Directed instructions: {valid,r1,r2,rd,use1,use2,rdata1,rdata2,imm,alu_op,alu_src,rw,mr,mw,m2r}
  localparam id_t LD5  = '{1'b1, 4'd1, 4'd0, 4'd5, 1'b1, 1'b0, 16'h1111, 16'h0000, 16'h0004, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam id_t ADD  = '{1'b1, 4'd3, 4'd5, 4'd6, 1'b1, 1'b1, 16'h3333, 16'h5555, 16'h0000, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam id_t LD0  = '{1'b1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0, 16'h2222, 16'h0000, 16'h0008, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam id_t R0U  = '{1'b1, 4'd0, 4'd0, 4'd7, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0007, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam id_t INV  = '{1'b0, 4'd5, 4'd5, 4'd9, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 16'hCCCC, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam id_t NUS  = '{1'b1, 4'd2, 4'd5, 4'd8, 1'b1, 1'b0, 16'h2222, 16'h5555, 16'h0010, 4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam id_t R1D  = '{1'b1, 4'd5, 4'd0, 4'd4, 1'b1, 1'b0, 16'h5555, 16'h0000, 16'h0020, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam id_t ZERO = '0;

  // Expected EX contents after capturing instruction i (use bits are not registered).
  function automatic id_t cap(id_t i);
    id_t r;
    r = i;
    r.use1 = 1'b0;
    r.use2 = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] cexp(logic [15:0] n);
`ifdef ID_EX_STALL_CNT_EN
    return n;
`else
    return 16'h0000 & n;
`endif
  endfunction

  function automatic id_t ex_now();
    id_t a;
    a = '{ex_valid, r1IDEX, r2IDEX, rdIDEX, 1'b0, 1'b0, ex_rdata1, ex_rdata2, ex_imm,
          ex_alu_op, ex_alu_src, regWriteIDEX, memReadIDEX, memWriteIDEX, memToRegIDEX};
    return a;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string name, input id_t i, input logic fl, input logic hd,
                      input logic es, input id_t eex, input logic [15:0] ecnt);
    exp_t e;
    @(negedge clk);
    id = i;
    flush = fl;
    ex_hold = hd;
    e.name = name;
    e.stall = es;
    e.ex = eex;
    e.cnt = ecnt;
    q.push_back(e);
  endtask

  // Monitor: stall_id checked after inputs settle, registered outputs checked after the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check({e.name, ".stall"}, 128'(stall_id), 128'(e.stall));
        @(posedge clk);
        #1;
        check({e.name, ".ex"}, 128'(ex_now()), 128'(e.ex));
        check({e.name, ".cnt"}, 128'(stall_count), 128'(e.cnt));
      end
    end
  end

  initial begin : driver
    int waited;
    id = ZERO;
    flush = 1'b0;
    ex_hold = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset.ex", 128'(ex_now()), 128'(ZERO));
    check("reset.cnt", 128'(stall_count), 128'(16'h0));
    check("reset.stall", 128'(stall_id), 128'(1'b0));
    #20;
    rst_n = 1'b1;

    step("ld5",       LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd0));
    step("lu_r2",     ADD, 1'b0, 1'b0, 1'b1, ZERO,     cexp(16'd1));
    step("after_lu",  ADD, 1'b0, 1'b0, 1'b0, cap(ADD), cexp(16'd1));
    step("ld0",       LD0, 1'b0, 1'b0, 1'b0, cap(LD0), cexp(16'd1));
    step("r0_nostall",R0U, 1'b0, 1'b0, 1'b0, cap(R0U), cexp(16'd1));
    step("ld5_b",     LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd1));
    step("flush_lu",  ADD, 1'b1, 1'b0, 1'b0, ZERO,     cexp(16'd1));
    step("ld5_c",     LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd1));
    step("hold1_lu",  ADD, 1'b0, 1'b1, 1'b1, cap(LD5), cexp(16'd1));
    step("hold2",     R0U, 1'b0, 1'b1, 1'b1, cap(LD5), cexp(16'd1));
    step("hold3",     LD0, 1'b0, 1'b1, 1'b1, cap(LD5), cexp(16'd1));
    step("lu_reeval", ADD, 1'b0, 1'b0, 1'b1, ZERO,     cexp(16'd2));
    step("add_cap",   ADD, 1'b0, 1'b0, 1'b0, cap(ADD), cexp(16'd2));
    step("invalid",   INV, 1'b0, 1'b0, 1'b0, cap(INV), cexp(16'd2));
    step("inv_nolu",  ADD, 1'b0, 1'b0, 1'b0, cap(ADD), cexp(16'd2));
    step("ld5_d",     LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd2));
    step("unused_r2", NUS, 1'b0, 1'b0, 1'b0, cap(NUS), cexp(16'd2));
    step("ld5_e",     LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd2));
    step("lu_r1",     R1D, 1'b0, 1'b0, 1'b1, ZERO,     cexp(16'd3));
    step("r1d_cap",   R1D, 1'b0, 1'b0, 1'b0, cap(R1D), cexp(16'd3));
    step("ld5_f",     LD5, 1'b0, 1'b0, 1'b0, cap(LD5), cexp(16'd3));

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", 128'(q.size()), 128'(0));
    repeat (2) @(negedge clk);

`ifdef ID_EX_STALL_CNT_EN
    for (int n = 0; n < 65537; n++) begin
      @(negedge clk);
      id = LD5;
      @(negedge clk);
      id = ADD;
    end
    @(negedge clk);
    id = ZERO;
    #1;
    check("cnt_saturate", 128'(stall_count), 128'(16'hFFFF));
`else
    check("cnt_tied_off", 128'(stall_count), 128'(16'h0000));
`endif

    // Reset mid-cycle while EX holds a load and a dependent instruction waits.
    @(negedge clk);
    id = LD5;
    @(negedge clk);
    id = ADD;
    #1;
    check("pre_reset.stall", 128'(stall_id), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset.ex", 128'(ex_now()), 128'(ZERO));
    check("mid_reset.stall", 128'(stall_id), 128'(1'b0));
    check("mid_reset.cnt", 128'(stall_count), 128'(16'h0));
    ex_hold = 1'b1;
    #1;
    check("reset_hold.stall", 128'(stall_id), 128'(1'b1));
    ex_hold = 1'b0;
    #10;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
